// File: rtl/wb_interconnect.sv
// Wishbone classic 1-master/3-slave address decoder with timeout; mapped hit answers 2 cycles after
// the request is seen (unmapped: 1), strobe held until a slave responds, master aborts or TIMEOUT expires.
module wb_interconnect #(
    parameter logic [31:0] S0_BASE = 32'h1000_0000,
    parameter logic [31:0] S0_SIZE = 32'h0020_0000,
    parameter logic [31:0] S1_BASE = 32'h2000_0000,
    parameter logic [31:0] S1_SIZE = 32'h0000_4000,
    parameter logic [31:0] S2_BASE = 32'h3000_0000,
    parameter logic [31:0] S2_SIZE = 32'h0000_1000,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        rty_o,
    output logic [2:0]  s_cyc_o,
    output logic [2:0]  s_stb_o,
    output logic [31:0] s_adr_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_dat_o,
    output logic        s_we_o,
    input  logic [95:0] s_dat_i,
    input  logic [2:0]  s_ack_i,
    input  logic [2:0]  s_err_i,
    input  logic [2:0]  s_rty_i
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

    state_t          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     dat_q, dat_d;
    logic            ack_q, ack_d, err_q, err_d, rty_q, rty_d;

    logic            hit;
    logic [1:0]      hit_k;
    logic            sr_ack, sr_err, sr_rty;
    logic [31:0]     sr_dat;

    function automatic logic in_rgn(input logic [31:0] a, input logic [31:0] base,
                                    input logic [31:0] size);
        logic [31:0] lim;
        lim = base + size;
        return (a >= base) && (a < lim);
    endfunction

    // Lowest-numbered region wins when windows overlap.
    always_comb begin
        hit   = 1'b1;
        hit_k = 2'd0;
        if (in_rgn(adr_i, S0_BASE, S0_SIZE))      hit_k = 2'd0;
        else if (in_rgn(adr_i, S1_BASE, S1_SIZE)) hit_k = 2'd1;
        else if (in_rgn(adr_i, S2_BASE, S2_SIZE)) hit_k = 2'd2;
        else                                      hit   = 1'b0;
    end

    always_comb begin
        sr_ack = 1'b0;
        sr_err = 1'b0;
        sr_rty = 1'b0;
        sr_dat = 32'h0;
        case (sel_q)
            2'd0: begin sr_ack = s_ack_i[0]; sr_err = s_err_i[0]; sr_rty = s_rty_i[0]; sr_dat = s_dat_i[31:0];  end
            2'd1: begin sr_ack = s_ack_i[1]; sr_err = s_err_i[1]; sr_rty = s_rty_i[1]; sr_dat = s_dat_i[63:32]; end
            2'd2: begin sr_ack = s_ack_i[2]; sr_err = s_err_i[2]; sr_rty = s_rty_i[2]; sr_dat = s_dat_i[95:64]; end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        dat_d   = dat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rty_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cyc_i && stb_i) begin
                    if (hit) begin
                        sel_d   = hit_k;
                        cnt_d   = '0;
                        state_d = ACTIVE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ACTIVE: begin
                if (!cyc_i) begin
                    state_d = IDLE;
                end else if (sr_ack || sr_err || sr_rty) begin
                    dat_d   = sr_dat;
                    err_d   = sr_err;
                    rty_d   = !sr_err && sr_rty;
                    ack_d   = !sr_err && !sr_rty;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            dat_q   <= 32'h0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rty_q   <= rty_d;
        end
    end

    // Response flags are only ever set on entry to RESP, so each lasts one cycle.
    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign rty_o   = rty_q;
    assign dat_o   = dat_q;

    assign s_cyc_o = (cyc_i && stb_i && state_q == ACTIVE) ? (3'b001 << sel_q) : 3'b000;
    assign s_stb_o = s_cyc_o;
    assign s_adr_o = adr_i;
    assign s_sel_o = sel_i;
    assign s_dat_o = dat_i;
    assign s_we_o  = we_i;
endmodule

// File: tb/tb_wb_interconnect.sv
// Directed bench for wb_interconnect: a per-cycle timeline of expected outputs built from the
// address map and response rules, compared every cycle, plus literal pins on key cycles.
module tb_wb_interconnect;
    localparam logic [31:0] B0 = 32'h1000_0000, Z0 = 32'h0020_0000;
    localparam logic [31:0] B1 = 32'h2000_0000, Z1 = 32'h0000_4000;
    localparam logic [31:0] B2 = 32'h3000_0000, Z2 = 32'h0000_1000;
    localparam int TO = 16;
    localparam int N  = 512;
    localparam int P_ACK = 0, P_ERR = 1, P_RTY = 2, P_STB = 3, P_DAT = 4, P_SEL = 5;

    logic        clk = 1'b0;
    logic        rst_i, cyc_i, stb_i, we_i;
    logic [31:0] adr_i, dat_i, dat_o, s_adr_o, s_dat_o;
    logic [3:0]  sel_i, s_sel_o;
    logic        ack_o, err_o, rty_o, s_we_o;
    logic [2:0]  s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i;
    logic [95:0] s_dat_i;

    always #5 clk = ~clk;

    wb_interconnect dut (
        .clk_i(clk), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .sel_i(sel_i), .dat_i(dat_i), .dat_o(dat_o),
        .ack_o(ack_o), .err_o(err_o), .rty_o(rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_adr_o(s_adr_o), .s_sel_o(s_sel_o),
        .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
    );

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    logic [2:0]  e_stb [N];
    logic        e_ack [N];
    logic        e_err [N];
    logic        e_rty [N];
    logic [31:0] e_dat [N];

    typedef struct {
        int          c;
        int          sig;
        logic [31:0] v;
    } pin_t;
    pin_t pins[$];

    int vectors = 0, miscompares = 0;
    bit chk_en = 1'b0;
    int cc;
    logic [31:0] act;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int decode(input logic [31:0] a);
        if (a >= B0 && a < B0 + Z0) return 0;
        if (a >= B1 && a < B1 + Z1) return 1;
        if (a >= B2 && a < B2 + Z2) return 2;
        return -1;
    endfunction

    function automatic void set_dat(input int from, input logic [31:0] v);
        for (int i = from; i < N; i++) e_dat[i] = v;
    endfunction

    task automatic pin(input int c, input int sig, input logic [31:0] v);
        pin_t p;
        p.c = c; p.sig = sig; p.v = v;
        pins.push_back(p);
    endtask

    // One transaction: slave responds with 'resp' ({rty,err,ack}) after d unanswered strobe
    // cycles (d >= TO means it never answers); 'noise' acks from other slaves while active.
    task automatic xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel, input int d,
                        input logic [2:0] resp, input logic [31:0] rdata, input logic [2:0] noise,
                        input bit hold);
        int c, k, n, r;
        logic [2:0] sb;
        c = cyc_n;
        k = decode(adr);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = adr ^ 32'h5A5A_0F0F;
        s_dat_i = {32'h2222_2222, 32'h1111_1111, 32'h0BAD_0000};
        if (k < 0) begin
            e_err[c+1] = 1'b1;
            step();
        end else begin
            s_dat_i[k*32 +: 32] = rdata;
            sb = 3'b001 << k;
            n = (d < TO) ? d + 1 : TO;
            for (int i = 1; i <= n; i++) e_stb[c+i] = sb;
            r = c + n + 1;
            if (d < TO) begin
                if (resp[1])      e_err[r] = 1'b1;
                else if (resp[2]) e_rty[r] = 1'b1;
                else              e_ack[r] = 1'b1;
                set_dat(r, rdata);
            end else begin
                e_err[r] = 1'b1;
            end
            step();
            for (int i = 0; i < n; i++) begin
                s_ack_i = noise | ((i == d && resp[0]) ? sb : 3'b000);
                s_err_i = (i == d && resp[1]) ? sb : 3'b000;
                s_rty_i = (i == d && resp[2]) ? sb : 3'b000;
                step();
            end
            s_ack_i = 3'b000; s_err_i = 3'b000; s_rty_i = 3'b000;
        end
        if (!hold) begin
            cyc_i = 1'b0; stb_i = 1'b0;
        end
        step();
    endtask

    task automatic reset_active();
        int c;
        c = cyc_n;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h3000_0100; sel_i = 4'hF;
        e_stb[c+1] = 3'b100;
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
        set_dat(c + 2, 32'h0);
        step();
    endtask

    task automatic abort_active();
        int c;
        c = cyc_n;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h1000_0200; sel_i = 4'hF;
        e_stb[c+1] = 3'b001;
        step();
        step();
        cyc_i = 1'b0; stb_i = 1'b0;
        step();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cc = cyc_n;
            vectors++;
            if ({s_cyc_o, s_stb_o, ack_o, err_o, rty_o, dat_o} !==
                {e_stb[cc], e_stb[cc], e_ack[cc], e_err[cc], e_rty[cc], e_dat[cc]}) begin
                miscompares++;
                $display("FAIL outputs cycle %0d: got cyc=%b stb=%b ack/err/rty=%b%b%b dat=%h, expected stb=%b ack/err/rty=%b%b%b dat=%h",
                         cc, s_cyc_o, s_stb_o, ack_o, err_o, rty_o, dat_o,
                         e_stb[cc], e_ack[cc], e_err[cc], e_rty[cc], e_dat[cc]);
            end
            vectors++;
            if ({s_adr_o, s_sel_o, s_dat_o, s_we_o} !== {adr_i, sel_i, dat_i, we_i}) begin
                miscompares++;
                $display("FAIL passthrough cycle %0d: got adr=%h sel=%b dat=%h we=%b, expected adr=%h sel=%b dat=%h we=%b",
                         cc, s_adr_o, s_sel_o, s_dat_o, s_we_o, adr_i, sel_i, dat_i, we_i);
            end
            foreach (pins[i]) begin
                if (pins[i].c == cc) begin
                    case (pins[i].sig)
                        P_ACK:   act = {31'h0, ack_o};
                        P_ERR:   act = {31'h0, err_o};
                        P_RTY:   act = {31'h0, rty_o};
                        P_STB:   act = {29'h0, s_stb_o};
                        P_DAT:   act = dat_o;
                        default: act = {28'h0, s_sel_o};
                    endcase
                    vectors++;
                    if (act !== pins[i].v) begin
                        miscompares++;
                        $display("FAIL pin cycle %0d sig %0d: got %h, expected %h", cc, pins[i].sig, act, pins[i].v);
                    end
                end
            end
        end
    end

    initial begin
        int c;
        foreach (e_stb[i]) begin
            e_stb[i] = 3'b000; e_ack[i] = 1'b0; e_err[i] = 1'b0; e_rty[i] = 1'b0; e_dat[i] = 32'h0;
        end
        rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = 32'h0; sel_i = 4'h0;
        dat_i = 32'h0; s_dat_i = 96'h0; s_ack_i = 3'b000; s_err_i = 3'b000; s_rty_i = 3'b000;
        step();
        step();
        rst_i = 1'b0;
        c = cyc_n;
        pin(c, P_STB, 32'h0); pin(c, P_ACK, 32'h0); pin(c, P_ERR, 32'h0); pin(c, P_DAT, 32'h0);
        chk_en = 1'b1;
        step();

        // Read from flash, acked in the first strobed cycle.
        c = cyc_n;
        pin(c+1, P_STB, 32'h1); pin(c+2, P_ACK, 32'h1); pin(c+2, P_DAT, 32'hDEAD_BEEF); pin(c+3, P_ACK, 32'h0);
        xfer(32'h1000_0010, 1'b0, 4'hF, 0, 3'b001, 32'hDEAD_BEEF, 3'b000, 1'b0);

        // Last word of memory, then one past its end.
        c = cyc_n;
        pin(c+1, P_STB, 32'h2); pin(c+1, P_SEL, 32'h3); pin(c+3, P_ACK, 32'h1);
        xfer(32'h2000_3FFC, 1'b1, 4'b0011, 1, 3'b001, 32'h1234_5678, 3'b000, 1'b0);
        c = cyc_n;
        pin(c+1, P_STB, 32'h0); pin(c+1, P_ERR, 32'h1);
        xfer(32'h2000_4000, 1'b1, 4'b0011, 0, 3'b001, 32'hFFFF_0000, 3'b000, 1'b0);

        // Control slave never answers.
        c = cyc_n;
        pin(c+16, P_STB, 32'h4); pin(c+17, P_STB, 32'h0); pin(c+17, P_ERR, 32'h1);
        pin(c+17, P_DAT, 32'h1234_5678); pin(c+18, P_ERR, 32'h0);
        xfer(32'h3000_0000, 1'b0, 4'hF, 99, 3'b000, 32'h0, 3'b000, 1'b0);

        // ack+err together, then a foreign ack from slave0 while slave1 is selected.
        c = cyc_n;
        pin(c+2, P_ERR, 32'h1); pin(c+2, P_ACK, 32'h0);
        xfer(32'h2000_0100, 1'b0, 4'hF, 0, 3'b011, 32'h5555_AAAA, 3'b000, 1'b0);
        c = cyc_n;
        pin(c+3, P_ACK, 32'h0); pin(c+4, P_ACK, 32'h1); pin(c+4, P_DAT, 32'h6666_0001);
        xfer(32'h2000_0200, 1'b0, 4'hF, 2, 3'b001, 32'h6666_0001, 3'b001, 1'b0);

        // Retry, and rty+ack together resolving to rty.
        c = cyc_n;
        pin(c+3, P_RTY, 32'h1);
        xfer(32'h3000_0FFC, 1'b0, 4'hF, 1, 3'b100, 32'h7777_0002, 3'b000, 1'b0);
        xfer(32'h3000_0004, 1'b0, 4'hF, 0, 3'b101, 32'h7777_0003, 3'b000, 1'b0);

        // Reset mid-transfer, then master abort.
        c = cyc_n;
        pin(c+2, P_STB, 32'h0); pin(c+2, P_ERR, 32'h0); pin(c+2, P_DAT, 32'h0);
        reset_active();
        c = cyc_n;
        pin(c+2, P_STB, 32'h0); pin(c+3, P_ACK, 32'h0); pin(c+3, P_ERR, 32'h0);
        abort_active();

        // Back-to-back: first with the request held through RESP, then newly asserted.
        c = cyc_n;
        pin(c+2, P_ACK, 32'h1); pin(c+2, P_STB, 32'h0); pin(c+3, P_ACK, 32'h0);
        pin(c+4, P_STB, 32'h2); pin(c+5, P_ACK, 32'h1); pin(c+5, P_DAT, 32'hBBBB_1111);
        xfer(32'h1000_0100, 1'b0, 4'hF, 0, 3'b001, 32'hAAAA_0000, 3'b000, 1'b1);
        xfer(32'h2000_0000, 1'b0, 4'hF, 0, 3'b001, 32'hBBBB_1111, 3'b000, 1'b0);
        xfer(32'h1000_0040, 1'b0, 4'hF, 0, 3'b001, 32'hCCCC_2222, 3'b000, 1'b0);
        xfer(32'h2000_0040, 1'b0, 4'hF, 1, 3'b001, 32'hDDDD_3333, 3'b000, 1'b0);

        // Region edges: flash end, below flash, control end.
        xfer(32'h101F_FFFC, 1'b0, 4'hF, 0, 3'b001, 32'h0F0F_1234, 3'b000, 1'b0);
        xfer(32'h1020_0000, 1'b0, 4'hF, 0, 3'b001, 32'h0, 3'b000, 1'b0);
        xfer(32'h0FFF_FFFC, 1'b0, 4'hF, 0, 3'b001, 32'h0, 3'b000, 1'b0);
        xfer(32'h3000_1000, 1'b0, 4'hF, 0, 3'b001, 32'h0, 3'b000, 1'b0);

        step();
        step();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
